// File: rtl/inst_fetch_unit_if.sv
// Bus bundle of the fetch unit: imem request/response, redirect and decode handshake.
// With FETCH_PERF_CNT_EN defined the bundle also carries the two perf counter outputs.
interface inst_fetch_unit_if #(
    parameter int PC_WIDTH = 64
);
    logic                out_imem_req;
    logic [PC_WIDTH-1:0] out_imem_addr;
    logic                in_imem_ready;
    logic                in_imem_rvalid;
    logic [31:0]         in_imem_rdata;
    logic                in_redirect_valid;
    logic [PC_WIDTH-1:0] in_redirect_pc;
    logic                out_inst_valid;
    logic [31:0]         out_inst;
    logic [PC_WIDTH-1:0] out_inst_pc;
    logic                in_inst_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]         out_perf_fetched;
    logic [31:0]         out_perf_stall;
`endif

    modport master (
        output out_imem_req, out_imem_addr,
        input  in_imem_ready, in_imem_rvalid, in_imem_rdata,
        input  in_redirect_valid, in_redirect_pc,
        output out_inst_valid, out_inst, out_inst_pc,
        input  in_inst_ready
`ifdef FETCH_PERF_CNT_EN
        , output out_perf_fetched, out_perf_stall
`endif
    );

    modport slave (
        input  out_imem_req, out_imem_addr,
        output in_imem_ready, in_imem_rvalid, in_imem_rdata,
        output in_redirect_valid, in_redirect_pc,
        input  out_inst_valid, out_inst, out_inst_pc,
        output in_inst_ready
`ifdef FETCH_PERF_CNT_EN
        , input out_perf_fetched, out_perf_stall
`endif
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, in-order response FIFO, redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/stall counters.
module inst_fetch_unit #(
    parameter int                     PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = {PC_WIDTH{1'b0}},
    parameter int                     DEPTH    = 2
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    inst_fetch_unit_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [PW-1:0] PONE_C  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [31:0]   NOP_C   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] pend_q [DEPTH];
    logic [PC_WIDTH-1:0] pend_d [DEPTH];
    logic [PW-1:0]       pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
    logic [CW-1:0]       outstanding_q, outstanding_d;
    logic [CW-1:0]       drop_cnt_q, drop_cnt_d;
    logic [31:0]         fifo_inst_q [DEPTH];
    logic [31:0]         fifo_inst_d [DEPTH];
    logic [PC_WIDTH-1:0] fifo_pc_q [DEPTH];
    logic [PC_WIDTH-1:0] fifo_pc_d [DEPTH];
    logic [PW-1:0]       fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d;

    logic                req_s, accept_s, ret_s, drop_s, pop_s, push_s;
    logic [CW-1:0]       inflight_s;

    // Handshake qualifiers; rvalid outside RUN/FLUSH or with nothing in flight is ignored.
    always_comb begin
        req_s    = (state_q == ST_RUN) && ((outstanding_q + fifo_cnt_q) < DEPTH_C);
        accept_s = req_s && bus.in_imem_ready;
        ret_s    = bus.in_imem_rvalid && (state_q == ST_RUN) && (outstanding_q != ZERO_C);
        drop_s   = bus.in_imem_rvalid && (state_q == ST_FLUSH) && (drop_cnt_q != ZERO_C);
        pop_s    = (fifo_cnt_q != ZERO_C) && bus.in_inst_ready && !bus.in_redirect_valid;
        push_s   = ret_s && !bus.in_redirect_valid;
        inflight_s = outstanding_q + {{(CW-1){1'b0}}, accept_s} - {{(CW-1){1'b0}}, ret_s};
    end

    // Next-state: redirect wins over every other event of the cycle.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pend_d        = pend_q;
        pend_rd_d     = pend_rd_q;
        pend_wr_d     = pend_wr_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_inst_d   = fifo_inst_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_cnt_d    = fifo_cnt_q;

        if (bus.in_redirect_valid) begin
            fetch_pc_d    = bus.in_redirect_pc & {{(PC_WIDTH-2){1'b1}}, 2'b00};
            pend_rd_d     = {PW{1'b0}};
            pend_wr_d     = {PW{1'b0}};
            fifo_rd_d     = {PW{1'b0}};
            fifo_wr_d     = {PW{1'b0}};
            fifo_cnt_d    = ZERO_C;
            outstanding_d = ZERO_C;
            if (state_q == ST_FLUSH) begin
                drop_cnt_d = drop_cnt_q - {{(CW-1){1'b0}}, drop_s};
            end else begin
                drop_cnt_d = inflight_s;
            end
        end else begin
            if (accept_s) begin
                pend_d[pend_wr_q] = fetch_pc_q;
                pend_wr_d         = pend_wr_q + PONE_C;
                fetch_pc_d        = fetch_pc_q + {{(PC_WIDTH-3){1'b0}}, 3'b100};
            end else begin
                pend_wr_d = pend_wr_q;
            end
            if (push_s) begin
                fifo_inst_d[fifo_wr_q] = bus.in_imem_rdata;
                fifo_pc_d[fifo_wr_q]   = pend_q[pend_rd_q];
                fifo_wr_d              = fifo_wr_q + PONE_C;
                pend_rd_d              = pend_rd_q + PONE_C;
            end else begin
                fifo_wr_d = fifo_wr_q;
            end
            if (pop_s) begin
                fifo_rd_d = fifo_rd_q + PONE_C;
            end else begin
                fifo_rd_d = fifo_rd_q;
            end
            fifo_cnt_d    = fifo_cnt_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
            outstanding_d = inflight_s;
            drop_cnt_d    = drop_cnt_q - {{(CW-1){1'b0}}, drop_s};
        end

        case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = (bus.in_redirect_valid && (inflight_s != ZERO_C)) ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = (drop_cnt_d == ZERO_C) ? ST_RUN : ST_FLUSH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            pend_rd_q     <= {PW{1'b0}};
            pend_wr_q     <= {PW{1'b0}};
            outstanding_q <= ZERO_C;
            drop_cnt_q    <= ZERO_C;
            fifo_rd_q     <= {PW{1'b0}};
            fifo_wr_q     <= {PW{1'b0}};
            fifo_cnt_q    <= ZERO_C;
            for (int i = 0; i < DEPTH; i++) begin
                pend_q[i]      <= {PC_WIDTH{1'b0}};
                fifo_inst_q[i] <= 32'h0000_0000;
                fifo_pc_q[i]   <= {PC_WIDTH{1'b0}};
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pend_rd_q     <= pend_rd_d;
            pend_wr_q     <= pend_wr_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            pend_q        <= pend_d;
            fifo_inst_q   <= fifo_inst_d;
            fifo_pc_q     <= fifo_pc_d;
        end
    end

    assign bus.out_imem_req   = req_s;
    assign bus.out_imem_addr  = fetch_pc_q;
    assign bus.out_inst_valid = (fifo_cnt_q != ZERO_C);
    assign bus.out_inst       = (fifo_cnt_q != ZERO_C) ? fifo_inst_q[fifo_rd_q] : NOP_C;
    assign bus.out_inst_pc    = (fifo_cnt_q != ZERO_C) ? fifo_pc_q[fifo_rd_q] : {PC_WIDTH{1'b0}};

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating counters; a stall is a RUN cycle with nothing to hand to decode.
    always_comb begin
        if (push_s && (perf_fetched_q != 32'hFFFF_FFFF)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end else begin
            perf_fetched_d = perf_fetched_q;
        end
        if ((state_q == ST_RUN) && (fifo_cnt_q == ZERO_C) && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Perf counter registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            perf_fetched_q <= 32'h0000_0000;
            perf_stall_q   <= 32'h0000_0000;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign bus.out_perf_fetched = perf_fetched_q;
    assign bus.out_perf_stall   = perf_stall_q;
`endif
endmodule
